// File: rtl/note_ball_engine.sv
// note_ball_engine: owns the single "note ball" glyph. It serves the ball,
// steps it across the playfield, opens each player's hit window as the ball
// approaches their side, judges incoming MIDI notes against the note the
// ball carries, and draws the ball by addressing the glyph ROM.
module note_ball_engine #(
    parameter int         GLYPH_W       = 8,
    parameter int         GLYPH_BASE    = 256,
    parameter int         X_MIN         = 60,
    parameter int         X_MAX         = 572,
    parameter int         P1_WIN_X      = 108,
    parameter int         P2_WIN_X      = 525,
    parameter logic [7:0] P1_LOW_NOTE   = 8'h24,
    parameter logic [7:0] P2_LOW_NOTE   = 8'h48,
    parameter int         ROW_BASE      = 401,
    parameter int         ROW_PITCH     = 15,
    parameter int         PARK_X        = 320,
    parameter int         PARK_Y        = 430,
    parameter int         MOVE_PERIOD   = 100000,
    parameter int         MIN_PERIOD    = 20000,
    parameter int         SPEEDUP       = 5000,
    parameter int         WINDOW_CYCLES = 25000000
) (
    input  logic        pixelClk,
    input  logic        reset,
    input  logic        enable,
    input  logic        noteValid,
    input  logic [7:0]  noteIn,
    input  logic [7:0]  nextNote,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [15:0] glyphData,
    output logic [9:0]  glyphMemAddress,
    output logic [7:0]  rgb,
    output logic        inGlyph,
    output logic [9:0]  ballX,
    output logic [9:0]  ballY,
    output logic        p1turn,
    output logic        p2turn,
    output logic        timerOn,
    output logic        correctNote,
    output logic        p1Miss,
    output logic        p2Miss
);

    // Counter widths sized from the slowest step period and the window length.
    localparam int PW = $clog2(MOVE_PERIOD + 1);
    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    localparam logic [7:0]    NOTE_SPAN    = 8'd24;
    localparam logic [7:0]    NOTE_OFFSET  = P2_LOW_NOTE - P1_LOW_NOTE;
    localparam logic [9:0]    X_MIN_C      = 10'(X_MIN);
    localparam logic [9:0]    X_MAX_C      = 10'(X_MAX);
    localparam logic [9:0]    X_MID_C      = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]    P1_WIN_C     = 10'(P1_WIN_X);
    localparam logic [9:0]    P2_WIN_C     = 10'(P2_WIN_X);
    localparam logic [9:0]    PARK_X_C     = 10'(PARK_X);
    localparam logic [9:0]    PARK_Y_C     = 10'(PARK_Y);
    localparam logic [9:0]    ROW_BASE_C   = 10'(ROW_BASE);
    localparam logic [9:0]    ROW_PITCH_C  = 10'(ROW_PITCH);
    localparam logic [9:0]    GLYPH_W_C    = 10'(GLYPH_W);
    localparam logic [9:0]    GLYPH_BASE_C = 10'(GLYPH_BASE);
    localparam logic [9:0]    X_ONE        = 10'd1;
    localparam logic [PW-1:0] PERIOD_INIT  = PW'(MOVE_PERIOD);
    localparam logic [PW-1:0] PERIOD_MIN   = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] PERIOD_STEP  = PW'(SPEEDUP);
    localparam logic [PW-1:0] PERIOD_ONE   = PW'(1);
    localparam logic [31:0]   SAT_LIMIT    = 32'(MIN_PERIOD + SPEEDUP);
    localparam logic [TW-1:0] WIN_LOAD     = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] WIN_ONE      = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_MOVE_R,
        S_WIN_R,
        S_MOVE_L,
        S_WIN_L
    } state_t;

    // True when note lies in the 24-note range starting at low; notes below
    // low wrap to large values and fall out of the range naturally.
    function automatic logic in_range(input logic [7:0] note, input logic [7:0] low);
        logic [7:0] rel;
        rel = note - low;
        return rel < NOTE_SPAN;
    endfunction

    // Screen row of a note already folded into the P1 range.
    function automatic logic [9:0] row_y(input logic [7:0] note);
        logic [7:0] rel;
        logic [9:0] idx;
        rel = note - P1_LOW_NOTE;
        idx = {2'b00, rel};
        return ROW_BASE_C - idx * ROW_PITCH_C;
    endfunction

    state_t        state_q;
    logic [9:0]    ball_x_q;
    logic [9:0]    ball_y_q;
    logic [7:0]    ball_note_q;
    logic [PW-1:0] period_q;
    logic [PW-1:0] tick_q;
    logic [TW-1:0] win_timer_q;
    logic          dir_right_q;
    logic          serve_right_q;
    logic          correct_q;
    logic          p1_miss_q;
    logic          p2_miss_q;

    logic          note_p1_d;
    logic          note_p2_d;
    logic [7:0]    note_fold_d;
    logic [7:0]    serve_note_d;
    logic [9:0]    serve_y_d;
    logic          step_d;
    logic [9:0]    x_step_d;
    logic [PW-1:0] period_fast_d;

    // Note classification, movement step and speed-up values for this cycle.
    always_comb begin
        note_p1_d   = in_range(noteIn, P1_LOW_NOTE);
        note_p2_d   = in_range(noteIn, P2_LOW_NOTE);
        note_fold_d = note_p2_d ? (noteIn - NOTE_OFFSET) : noteIn;

        // An invalid next note still gives the ball a playable note.
        if (in_range(nextNote, P1_LOW_NOTE)) begin
            serve_note_d = nextNote;
        end else if (in_range(nextNote, P2_LOW_NOTE)) begin
            serve_note_d = nextNote - NOTE_OFFSET;
        end else begin
            serve_note_d = P1_LOW_NOTE;
        end
        serve_y_d = row_y(serve_note_d);

        // >= rather than == so a period shortened mid-count still wraps.
        step_d   = (tick_q >= (period_q - PERIOD_ONE));
        x_step_d = dir_right_q ? (ball_x_q + X_ONE) : (ball_x_q - X_ONE);

        period_fast_d = (32'(period_q) > SAT_LIMIT) ? (period_q - PERIOD_STEP) : PERIOD_MIN;
    end

    // Serve / flight / window state machine with all registered outputs.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ball_x_q      <= PARK_X_C;
            ball_y_q      <= PARK_Y_C;
            ball_note_q   <= 8'd0;
            period_q      <= PERIOD_INIT;
            tick_q        <= '0;
            win_timer_q   <= '0;
            dir_right_q   <= 1'b1;
            serve_right_q <= 1'b1;
            correct_q     <= 1'b1;
            p1_miss_q     <= 1'b0;
            p2_miss_q     <= 1'b0;
        end else begin
            p1_miss_q <= 1'b0;
            p2_miss_q <= 1'b0;
            if (!enable) begin
                // Leaving play parks the ball but keeps the earned speed.
                state_q  <= S_IDLE;
                ball_x_q <= PARK_X_C;
                ball_y_q <= PARK_Y_C;
                tick_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ball_x_q <= PARK_X_C;
                        ball_y_q <= PARK_Y_C;
                        tick_q   <= '0;
                        state_q  <= S_SERVE;
                    end
                    S_SERVE: begin
                        ball_note_q <= serve_note_d;
                        ball_y_q    <= serve_y_d;
                        ball_x_q    <= X_MID_C;
                        tick_q      <= '0;
                        dir_right_q <= serve_right_q;
                        state_q     <= serve_right_q ? S_MOVE_R : S_MOVE_L;
                    end
                    default: begin
                        // The ball keeps flying (and bouncing) in every play state.
                        tick_q <= step_d ? '0 : (tick_q + PERIOD_ONE);
                        if (step_d) begin
                            ball_x_q <= x_step_d;
                            if (x_step_d >= X_MAX_C) begin
                                dir_right_q <= 1'b0;
                            end else if (x_step_d <= X_MIN_C) begin
                                dir_right_q <= 1'b1;
                            end
                        end
                        case (state_q)
                            S_MOVE_R: begin
                                if (step_d && (x_step_d >= P2_WIN_C)) begin
                                    state_q     <= S_WIN_R;
                                    win_timer_q <= WIN_LOAD;
                                end
                            end
                            S_MOVE_L: begin
                                if (step_d && (x_step_d <= P1_WIN_C)) begin
                                    state_q     <= S_WIN_L;
                                    win_timer_q <= WIN_LOAD;
                                end
                            end
                            S_WIN_R: begin
                                // A judged note beats a timeout in the same cycle.
                                if (noteValid && note_p2_d) begin
                                    if (note_fold_d == ball_note_q) begin
                                        correct_q   <= 1'b1;
                                        ball_note_q <= serve_note_d;
                                        ball_y_q    <= serve_y_d;
                                        period_q    <= period_fast_d;
                                        dir_right_q <= 1'b0;
                                        state_q     <= S_MOVE_L;
                                    end else begin
                                        correct_q     <= 1'b0;
                                        p2_miss_q     <= 1'b1;
                                        serve_right_q <= 1'b1;
                                        state_q       <= S_SERVE;
                                    end
                                end else if (win_timer_q == '0) begin
                                    correct_q     <= 1'b0;
                                    p2_miss_q     <= 1'b1;
                                    serve_right_q <= 1'b1;
                                    state_q       <= S_SERVE;
                                end else begin
                                    win_timer_q <= win_timer_q - WIN_ONE;
                                end
                            end
                            S_WIN_L: begin
                                if (noteValid && note_p1_d) begin
                                    if (note_fold_d == ball_note_q) begin
                                        correct_q   <= 1'b1;
                                        ball_note_q <= serve_note_d;
                                        ball_y_q    <= serve_y_d;
                                        period_q    <= period_fast_d;
                                        dir_right_q <= 1'b1;
                                        state_q     <= S_MOVE_R;
                                    end else begin
                                        correct_q     <= 1'b0;
                                        p1_miss_q     <= 1'b1;
                                        serve_right_q <= 1'b0;
                                        state_q       <= S_SERVE;
                                    end
                                end else if (win_timer_q == '0) begin
                                    correct_q     <= 1'b0;
                                    p1_miss_q     <= 1'b1;
                                    serve_right_q <= 1'b0;
                                    state_q       <= S_SERVE;
                                end else begin
                                    win_timer_q <= win_timer_q - WIN_ONE;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign ballX       = ball_x_q;
    assign ballY       = ball_y_q;
    assign p1turn      = (state_q == S_WIN_L);
    assign p2turn      = (state_q == S_WIN_R);
    assign timerOn     = p1turn | p2turn;
    assign correctNote = correct_q;
    assign p1Miss      = p1_miss_q;
    assign p2Miss      = p2_miss_q;

    // Glyph-relative pixel offsets; the explicit >= guards stop wrap-around
    // from faking a hit when the ball sits near the right/bottom edge.
    logic [9:0] dx_d;
    logic [9:0] dy_d;
    logic       in_glyph_d;

    assign dx_d       = hCount - ball_x_q;
    assign dy_d       = vCount - ball_y_q;
    assign in_glyph_d = (hCount >= ball_x_q) && (dx_d < GLYPH_W_C) &&
                        (vCount >= ball_y_q) && (dy_d < GLYPH_W_C);

    assign inGlyph         = in_glyph_d;
    assign glyphMemAddress = in_glyph_d ? (GLYPH_BASE_C + dx_d + dy_d * GLYPH_W_C) : GLYPH_BASE_C;
    assign rgb             = glyphData[7:0];

    // The upper ROM byte carries nothing the ball needs.
    logic unused_glyph_hi;
    assign unused_glyph_hi = ^glyphData[15:8];

endmodule

// File: tb/tb_note_ball_engine.sv
`timescale 1ns/1ps
module tb_note_ball_engine;

    localparam int X_MIN         = 60;
    localparam int X_MAX         = 80;
    localparam int P1_WIN_X      = 64;
    localparam int P2_WIN_X      = 76;
    localparam int MOVE_PERIOD   = 4;
    localparam int MIN_PERIOD    = 2;
    localparam int SPEEDUP       = 1;
    localparam int WINDOW_CYCLES = 16;
    localparam int GLYPH_W       = 8;
    localparam int GLYPH_BASE    = 256;
    localparam int ROW_BASE      = 401;
    localparam int ROW_PITCH     = 15;
    localparam int PARK_X        = 320;
    localparam int PARK_Y        = 430;
    localparam int P1_LO         = 36;   // 8'h24
    localparam int P2_LO         = 72;   // 8'h48
    localparam int N_CYCLES      = 3000;

    logic        pixelClk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        noteValid = 1'b0;
    logic [7:0]  noteIn = 8'd0;
    logic [7:0]  nextNote = 8'd0;
    logic [9:0]  hCount = 10'd0;
    logic [9:0]  vCount = 10'd0;
    logic [15:0] glyphData = 16'd0;
    logic [9:0]  glyphMemAddress;
    logic [7:0]  rgb;
    logic        inGlyph;
    logic [9:0]  ballX;
    logic [9:0]  ballY;
    logic        p1turn;
    logic        p2turn;
    logic        timerOn;
    logic        correctNote;
    logic        p1Miss;
    logic        p2Miss;

    note_ball_engine #(
        .GLYPH_W(GLYPH_W), .GLYPH_BASE(GLYPH_BASE),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .P1_WIN_X(P1_WIN_X), .P2_WIN_X(P2_WIN_X),
        .P1_LOW_NOTE(8'h24), .P2_LOW_NOTE(8'h48),
        .ROW_BASE(ROW_BASE), .ROW_PITCH(ROW_PITCH), .PARK_X(PARK_X), .PARK_Y(PARK_Y),
        .MOVE_PERIOD(MOVE_PERIOD), .MIN_PERIOD(MIN_PERIOD), .SPEEDUP(SPEEDUP),
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) dut (
        .pixelClk(pixelClk), .reset(reset), .enable(enable),
        .noteValid(noteValid), .noteIn(noteIn), .nextNote(nextNote),
        .hCount(hCount), .vCount(vCount), .glyphData(glyphData),
        .glyphMemAddress(glyphMemAddress), .rgb(rgb), .inGlyph(inGlyph),
        .ballX(ballX), .ballY(ballY), .p1turn(p1turn), .p2turn(p2turn),
        .timerOn(timerOn), .correctNote(correctNote), .p1Miss(p1Miss), .p2Miss(p2Miss)
    );

    initial forever #5 pixelClk = ~pixelClk;

    // ---------------- reference model (game rules, plain integers) ----------
    localparam int M_PARKED  = 0;
    localparam int M_SERVING = 1;
    localparam int M_FLYING  = 2;

    int m_mode = M_PARKED;
    int m_win = 0;             // 0 none, 1 = P1 window, 2 = P2 window
    int m_x = PARK_X;
    int m_y = PARK_Y;
    int m_note = 0;
    int m_right = 1;
    int m_serve_right = 1;
    int m_period = MOVE_PERIOD;
    int m_phase = 0;
    int m_left = 0;            // window cycles left after this one
    int m_correct = 1;
    int m_miss1 = 0;
    int m_miss2 = 0;
    int m_hit = 0;

    function automatic int fold(input int n);
        if (n >= P1_LO && n < P1_LO + 24) return n;
        if (n >= P2_LO && n < P2_LO + 24) return n - (P2_LO - P1_LO);
        return -1;
    endfunction

    function automatic int serve_note(input int n);
        int f;
        f = fold(n);
        return (f < 0) ? P1_LO : f;
    endfunction

    function automatic int row_of(input int n);
        return ROW_BASE - ROW_PITCH * (n - P1_LO);
    endfunction

    task automatic model_lose();
        m_correct = 0;
        if (m_win == 2) begin
            m_miss2 = 1;
            m_serve_right = 1;
        end else begin
            m_miss1 = 1;
            m_serve_right = 0;
        end
        m_win = 0;
        m_mode = M_SERVING;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit nv, input int nin, input int nxt);
        int owner_lo;
        bit stepped;
        bit was_right;
        m_miss1 = 0;
        m_miss2 = 0;
        m_hit = 0;
        if (rst) begin
            m_mode = M_PARKED; m_win = 0; m_x = PARK_X; m_y = PARK_Y;
            m_period = MOVE_PERIOD; m_phase = 0; m_left = 0; m_correct = 1;
            m_note = 0; m_right = 1; m_serve_right = 1;
        end else if (!en) begin
            m_mode = M_PARKED; m_win = 0; m_x = PARK_X; m_y = PARK_Y; m_phase = 0;
        end else if (m_mode == M_PARKED) begin
            m_mode = M_SERVING;
        end else if (m_mode == M_SERVING) begin
            m_note = serve_note(nxt);
            m_y = row_of(m_note);
            m_x = (X_MIN + X_MAX) / 2;
            m_phase = 0;
            m_right = m_serve_right;
            m_mode = M_FLYING;
        end else begin
            was_right = (m_right != 0);
            stepped = (m_phase + 1 >= m_period);
            m_phase = stepped ? 0 : m_phase + 1;
            if (stepped) begin
                m_x = m_x + (was_right ? 1 : -1);
                if (m_x >= X_MAX) m_right = 0;
                else if (m_x <= X_MIN) m_right = 1;
            end
            if (m_win == 0) begin
                if (stepped && was_right && m_x >= P2_WIN_X) begin
                    m_win = 2; m_left = WINDOW_CYCLES - 1;
                end else if (stepped && !was_right && m_x <= P1_WIN_X) begin
                    m_win = 1; m_left = WINDOW_CYCLES - 1;
                end
            end else begin
                owner_lo = (m_win == 2) ? P2_LO : P1_LO;
                if (nv && nin >= owner_lo && nin < owner_lo + 24) begin
                    if (nin - owner_lo + P1_LO == m_note) begin
                        m_hit = m_win;
                        m_correct = 1;
                        m_note = serve_note(nxt);
                        m_y = row_of(m_note);
                        m_period = (m_period - SPEEDUP < MIN_PERIOD) ? MIN_PERIOD : m_period - SPEEDUP;
                        m_right = (m_win == 1) ? 1 : 0;
                        m_win = 0;
                    end else begin
                        model_lose();
                    end
                end else if (m_left == 0) begin
                    model_lose();
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int x; int y; int p1; int p2; int tmr; int correct;
        int miss1; int miss2; int ing; int addr; int rgb;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge pixelClk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ballX", int'(ballX), e.x);
                check("ballY", int'(ballY), e.y);
                check("p1turn", int'(p1turn), e.p1);
                check("p2turn", int'(p2turn), e.p2);
                check("timerOn", int'(timerOn), e.tmr);
                check("correctNote", int'(correctNote), e.correct);
                check("p1Miss", int'(p1Miss), e.miss1);
                check("p2Miss", int'(p2Miss), e.miss2);
                check("inGlyph", int'(inGlyph), e.ing);
                check("glyphMemAddress", int'(glyphMemAddress), e.addr);
                check("rgb", int'(rgb), e.rgb);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver: random play with a per-window plan, model step, expected push.
    initial begin : driver
        int plan_kind;
        int plan_t;
        int prev_win;
        int en_off;
        plan_kind = 0;
        plan_t = 0;
        prev_win = 0;
        en_off = 0;
        for (int c = 0; c < N_CYCLES; c++) begin
            bit r;
            bit e;
            bit v;
            int ni;
            int nx;
            int k;
            int h;
            int vv;
            int base;
            exp_t ex;
            @(negedge pixelClk);

            r = (c < 2) || ($urandom_range(0, 899) == 0) ||
                (m_win == 2 && $urandom_range(0, 149) == 0);
            if (en_off > 0) begin
                e = 0;
                en_off--;
            end else if (c >= 2 && ($urandom_range(0, 299) == 0 ||
                                    (m_win != 0 && $urandom_range(0, 79) == 0))) begin
                e = 0;
                en_off = int'($urandom_range(0, 2));
            end else begin
                e = 1;
            end

            k = int'($urandom_range(0, 7));
            if (k < 4)      nx = P1_LO + int'($urandom_range(0, 23));
            else if (k < 7) nx = P2_LO + int'($urandom_range(0, 23));
            else            nx = int'($urandom_range(0, 127));

            v = 0;
            ni = int'($urandom_range(0, 127));
            if (m_win != 0) begin
                if (plan_kind != 0 && m_left == plan_t) begin
                    base = m_note;
                    if (plan_kind == 2)
                        base = P1_LO + ((m_note - P1_LO + int'($urandom_range(1, 23))) % 24);
                    v = 1;
                    ni = (m_win == 2) ? base + (P2_LO - P1_LO) : base;
                end else if ($urandom_range(0, 3) == 0) begin
                    k = int'($urandom_range(0, 2));
                    if (k == 0) begin
                        v = 1;
                        ni = ((m_win == 2) ? P1_LO : P2_LO) + int'($urandom_range(0, 23));
                    end else if (k == 1) begin
                        v = 1;
                        k = int'($urandom_range(0, 2));
                        ni = (k == 0) ? int'($urandom_range(0, 35)) :
                             (k == 1) ? int'($urandom_range(60, 71)) : int'($urandom_range(96, 127));
                    end else begin
                        v = 0;
                        ni = (m_win == 2) ? m_note + (P2_LO - P1_LO) : m_note;
                    end
                end
            end else if ($urandom_range(0, 5) == 0) begin
                v = 1;
            end

            reset = r;
            enable = e;
            noteValid = v;
            noteIn = 8'(ni);
            nextNote = 8'(nx);

            model_step(r, e, v, ni, nx);

            if (r && c >= 2) $display("cycle %0d: reset pulse", c);
            if (!r && !e && prev_win != 0) $display("cycle %0d: enable dropped mid-window", c);
            if (m_hit != 0)
                $display("cycle %0d: P%0d hit note %02h, next note %02h, period %0d", c, m_hit, ni, m_note, m_period);
            if (m_miss1 != 0 || m_miss2 != 0)
                $display("cycle %0d: P%0d miss (%s)", c, (m_miss1 != 0) ? 1 : 2, v ? "wrong note" : "timeout");

            if (m_win != 0 && prev_win == 0) begin
                plan_kind = int'($urandom_range(0, 3));
                if (plan_kind == 3) plan_kind = 1;
                plan_t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, WINDOW_CYCLES - 1));
            end
            prev_win = m_win;

            h = m_x + int'($urandom_range(0, 12)) - 2;
            vv = m_y + int'($urandom_range(0, 12)) - 2;
            if (h < 0) h = 0;
            if (h > 1023) h = 1023;
            if (vv < 0) vv = 0;
            if (vv > 1023) vv = 1023;
            hCount = 10'(h);
            vCount = 10'(vv);
            glyphData = 16'($urandom);

            ex.x = m_x;
            ex.y = m_y;
            ex.p1 = (m_win == 1) ? 1 : 0;
            ex.p2 = (m_win == 2) ? 1 : 0;
            ex.tmr = (m_win != 0) ? 1 : 0;
            ex.correct = m_correct;
            ex.miss1 = m_miss1;
            ex.miss2 = m_miss2;
            ex.ing = (h >= m_x && h < m_x + GLYPH_W && vv >= m_y && vv < m_y + GLYPH_W) ? 1 : 0;
            ex.addr = ex.ing ? GLYPH_BASE + (h - m_x) + GLYPH_W * (vv - m_y) : GLYPH_BASE;
            ex.rgb = int'(glyphData[7:0]);
            exp_q.push_back(ex);
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge pixelClk);
        @(posedge pixelClk);
        #2;
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
